// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parameterised up/down modulus counter with wrap or saturate mode
module updown_counter_param #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int              SATURATE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_down,
   input  logic [WIDTH-1:0] step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             sat,
   output logic             at_max,
   output logic             at_min
);

   // One guard bit keeps count+step and MODULUS itself (up to 2^WIDTH) exact.
   localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             wrap_q, wrap_d;
   logic             sat_q, sat_d;

   logic [WIDTH:0]   cnt_x;
   logic [WIDTH:0]   step_x;
   logic [WIDTH:0]   eff_s;
   logic [WIDTH:0]   ld_x;
   logic [WIDTH:0]   ld_eff;
   logic [WIDTH:0]   sum_x;
   logic [WIDTH:0]   up_wrap_x;
   logic [WIDTH:0]   diff_x;
   logic [WIDTH:0]   dn_wrap_x;
   logic             cross_up;
   logic             cross_dn;
   logic [WIDTH:0]   next_x;
   logic             unused_next_msb;

   // Operand clamping and the candidate results for every direction/mode.
   always_comb begin
      cnt_x     = {1'b0, count_q};
      step_x    = {1'b0, step};
      ld_x      = {1'b0, load_val};
      eff_s     = (step_x > MAX_W) ? MAX_W : step_x;
      ld_eff    = (ld_x > MAX_W) ? MAX_W : ld_x;
      sum_x     = cnt_x + eff_s;
      cross_up  = (sum_x > MAX_W);
      cross_dn  = (eff_s > cnt_x);
      up_wrap_x = sum_x - MOD_W;
      diff_x    = cnt_x - eff_s;
      // Subtract first so the down-wrap never needs more than WIDTH+1 bits.
      dn_wrap_x = (MOD_W - eff_s) + cnt_x;
   end

   // Next-state selection: load beats enable, enable beats hold.
   always_comb begin
      next_x = {1'b0, count_q};
      wrap_d = 1'b0;
      sat_d  = 1'b0;
      if (load) begin
         next_x = ld_eff;
      end else if (en) begin
         if (up_down) begin
            if (!cross_up) begin
               next_x = sum_x;
            end else if (SATURATE != 0) begin
               next_x = MAX_W;
               sat_d  = 1'b1;
            end else begin
               next_x = up_wrap_x;
               wrap_d = 1'b1;
            end
         end else begin
            if (!cross_dn) begin
               next_x = diff_x;
            end else if (SATURATE != 0) begin
               next_x = '0;
               sat_d  = 1'b1;
            end else begin
               next_x = dn_wrap_x;
               wrap_d = 1'b1;
            end
         end
      end
      // Every selected value is below MODULUS, so the guard bit is always zero here.
      count_d         = next_x[WIDTH-1:0];
      unused_next_msb = next_x[WIDTH];
   end

   // State register; reset clears the count and any pending pulse immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         sat_q   <= sat_d;
      end
   end

   // Boundary flags decode the registered count only.
   always_comb begin
      count  = count_q;
      wrap   = wrap_q;
      sat    = sat_q;
      at_max = ({1'b0, count_q} == MAX_W);
      at_min = (count_q == '0);
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench for updown_counter_param
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up_down;
   logic       load;
   logic [3:0] step;
   logic [3:0] load_val;

   logic [3:0] cnt_o  [3];
   logic       wrap_o [3];
   logic       sat_o  [3];
   logic       max_o  [3];
   logic       min_o  [3];

   typedef struct {
      int         at;
      int         dut;
      int         id;
      logic [7:0] v;
   } exp_t;

   exp_t sync_q[$];
   exp_t async_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   id_n   = 0;
   event chk_ev;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_wrap10 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
      .load(load), .load_val(load_val), .count(cnt_o[0]), .wrap(wrap_o[0]),
      .sat(sat_o[0]), .at_max(max_o[0]), .at_min(min_o[0]));

   updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_sat10 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
      .load(load), .load_val(load_val), .count(cnt_o[1]), .wrap(wrap_o[1]),
      .sat(sat_o[1]), .at_max(max_o[1]), .at_min(min_o[1]));

   updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_wrap16 (
      .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
      .load(load), .load_val(load_val), .count(cnt_o[2]), .wrap(wrap_o[2]),
      .sat(sat_o[2]), .at_max(max_o[2]), .at_min(min_o[2]));

   function automatic logic [7:0] observe(input int d);
      return {cnt_o[d], wrap_o[d], sat_o[d], max_o[d], min_o[d]};
   endfunction

   task automatic compare(input exp_t e);
      logic [7:0] g;
      g = observe(e.dut);
      n_chk++;
      if (g !== e.v) begin
         n_fail++;
         $display("FAIL chk%0d dut%0d: got cnt=%0d wrap=%0b sat=%0b max=%0b min=%0b, expected cnt=%0d wrap=%0b sat=%0b max=%0b min=%0b",
                  e.id, e.dut, g[7:4], g[3], g[2], g[1], g[0],
                  e.v[7:4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
   endtask

   // Monitor for registered results: one slot per clock, sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sync_q.size() > 0 && sync_q[0].at <= cyc) begin
            e = sync_q.pop_front();
            compare(e);
         end
      end
   end

   // Monitor for checks taken between clock edges.
   initial begin
      exp_t e;
      forever begin
         @(chk_ev);
         while (async_q.size() > 0) begin
            e = async_q.pop_front();
            compare(e);
         end
      end
   end

   task automatic drive(input logic ld, input logic [3:0] lv, input logic e,
                        input logic ud, input logic [3:0] st);
      @(negedge clk);
      load     = ld;
      load_val = lv;
      en       = e;
      up_down  = ud;
      step     = st;
   endtask

   task automatic cyc_chk(input logic ld, input logic [3:0] lv, input logic e,
                          input logic ud, input logic [3:0] st, input int d,
                          input logic [3:0] c, input logic w, input logic s,
                          input logic mx, input logic mn);
      exp_t x;
      drive(ld, lv, e, ud, st);
      x.at  = cyc + 1;
      x.dut = d;
      x.id  = id_n;
      x.v   = {c, w, s, mx, mn};
      id_n++;
      sync_q.push_back(x);
   endtask

   task automatic expect_now(input int d, input logic [3:0] c, input logic w,
                             input logic s, input logic mx, input logic mn);
      exp_t x;
      x.at  = cyc;
      x.dut = d;
      x.id  = id_n;
      x.v   = {c, w, s, mx, mn};
      id_n++;
      async_q.push_back(x);
      ->chk_ev;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [3:0] up_seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

   initial begin
      reset = 1'b0; en = 1'b0; up_down = 1'b0; load = 1'b0;
      step = 4'd0; load_val = 4'd0;
      @(negedge clk);
      @(negedge clk);
      expect_now(0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      expect_now(1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;

      // Count up by one through the modulus: single wrap on 9 -> 0.
      for (int k = 0; k < 12; k++)
         cyc_chk(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 0, up_seq[k], (k == 9),
                 1'b0, (up_seq[k] == 4'd9), (up_seq[k] == 4'd0));

      // Down by three from 2 wraps to 9, then 6.
      cyc_chk(1'b1, 4'd2,  1'b0, 1'b0, 4'd0,  0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      // Load clamps and wins over en; oversized step clamps to 9.
      cyc_chk(1'b1, 4'd15, 1'b1, 1'b1, 4'd1,  0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd12, 0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      // Hold, zero step, direction changes without a dead cycle.
      cyc_chk(1'b0, 4'd0,  1'b0, 1'b1, 4'd12, 0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd0,  0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      // Exact landing on 0 is not a crossing; stepping down from 0 is.
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd8,  0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd1,  0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      // Back-to-back wraps keep wrap high, then it drops.
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Saturate mode, modulus 10.
      cyc_chk(1'b1, 4'd8,  1'b0, 1'b0, 4'd0,  1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd5,  1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd5,  1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd7,  1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc_chk(1'b0, 4'd0,  1'b0, 1'b0, 4'd7,  1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc_chk(1'b1, 4'd15, 1'b0, 1'b0, 4'd0,  1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);

      // Full-range modulus 16: no overflow at the top.
      cyc_chk(1'b1, 4'd15, 1'b0, 1'b0, 4'd0,  2, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  2, 4'd0,  1'b1, 1'b0, 1'b0, 1'b1);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd15, 2, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b0, 4'd15, 2, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset while count=5 and wrap is high.
      cyc_chk(1'b1, 4'd9,  1'b0, 1'b0, 4'd0,  0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 1'b1, 4'd6);
      @(posedge clk);
      #1;
      expect_now(0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      expect_now(0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Reset overrides load across a clock edge.
      cyc_chk(1'b1, 4'd7,  1'b1, 1'b1, 4'd1,  0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 1'b1, 4'd1);
      reset = 1'b1;
      cyc_chk(1'b0, 4'd0,  1'b1, 1'b1, 4'd1,  0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      #1;
      if (sync_q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sync_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
